// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token values, token helpers and the
// receiver alignment state type.
package tmds_pkg;

    localparam logic [9:0] TMDS_TOK_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_TOK_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_TOK_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_TOK_11 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } rx_state_e;

    function automatic logic tmds_is_token(input logic [9:0] sym);
        return (sym == TMDS_TOK_00) || (sym == TMDS_TOK_01) ||
               (sym == TMDS_TOK_10) || (sym == TMDS_TOK_11);
    endfunction

    function automatic logic [1:0] tmds_cd_of(input logic [9:0] sym);
        logic [1:0] code;
        code = 2'b00;
        case (sym)
            TMDS_TOK_01: code = 2'b01;
            TMDS_TOK_10: code = 2'b10;
            TMDS_TOK_11: code = 2'b11;
            default:     code = 2'b00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: one 10-bit symbol to either a control
// code (de=0) or a video byte (de=1).
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       de,
    output logic [7:0] vd,
    output logic [1:0] cd
);

    logic [7:0] q;

    always_comb begin
        q  = sym[9] ? ~sym[7:0] : sym[7:0];
        de = !tmds_is_token(sym);
        cd = de ? 2'b00 : tmds_cd_of(sym);
        vd = 8'h00;
        if (de) begin
            vd[0] = q[0];
            // b8 selects between the XOR and XNOR transition chains
            for (int i = 1; i < 8; i++) begin
                vd[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
            end
        end
    end

endmodule

// File: rtl/tmds_channel_receiver.sv
// One TMDS lane receiver: finds the 10-bit symbol boundary from control-token
// runs, tracks loss of alignment, and emits decoded video/control per clk.
module tmds_channel_receiver
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS  = 8,
    parameter int SEARCH_WORDS = 2048,
    parameter int LOSS_WORDS   = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] din,
    output logic [7:0] vd,
    output logic [1:0] cd,
    output logic       de,
    output logic       locked,
    output logic [3:0] align_offset,
    output logic       realign
);

    localparam int TOK_W  = $clog2(LOCK_TOKENS);
    localparam int WAIT_W = $clog2(SEARCH_WORDS);
    localparam int LOSS_W = $clog2(LOSS_WORDS);
    localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(LOCK_TOKENS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SEARCH_WORDS - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WORDS - 1);

    rx_state_e         state, state_nxt;
    logic [TOK_W-1:0]  tok_cnt, tok_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [LOSS_W-1:0] loss_cnt, loss_cnt_nxt;
    logic [3:0]        off_nxt;
    logic              realign_nxt;

    logic [9:0]  prev_p0;
    logic [19:0] win_p0;
    logic [9:0]  sym_p0;
    logic        dec_de_p0;
    logic [7:0]  dec_vd_p0;
    logic [1:0]  dec_cd_p0;

    // ---- stage p0: previous word captured; symbol selected from the window
    always_ff @(posedge clk) begin
        prev_p0 <= din;
    end

    // Earlier word sits in the low half because bit0 arrives first on the wire
    assign win_p0 = {din, prev_p0};
    assign sym_p0 = 10'(win_p0 >> align_offset);

    tmds_symbol_decode u_decode (
        .sym (sym_p0),
        .de  (dec_de_p0),
        .vd  (dec_vd_p0),
        .cd  (dec_cd_p0)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SEARCH;
            tok_cnt      <= '0;
            wait_cnt     <= '0;
            loss_cnt     <= '0;
            align_offset <= 4'd0;
            realign      <= 1'b0;
        end else begin
            state        <= state_nxt;
            tok_cnt      <= tok_cnt_nxt;
            wait_cnt     <= wait_cnt_nxt;
            loss_cnt     <= loss_cnt_nxt;
            align_offset <= off_nxt;
            realign      <= realign_nxt;
        end
    end

    // Counters are cleared at their terminal value, so none can wrap.
    always_comb begin
        state_nxt    = state;
        tok_cnt_nxt  = tok_cnt;
        wait_cnt_nxt = wait_cnt;
        loss_cnt_nxt = loss_cnt;
        off_nxt      = align_offset;
        realign_nxt  = 1'b0;
        case (state)
            SEARCH: begin
                if (!dec_de_p0) begin
                    if (tok_cnt == TOK_LAST) begin
                        state_nxt    = LOCKED;
                        tok_cnt_nxt  = '0;
                        wait_cnt_nxt = '0;
                        loss_cnt_nxt = '0;
                    end else begin
                        tok_cnt_nxt = tok_cnt + 1'b1;
                    end
                end else begin
                    tok_cnt_nxt = '0;
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt_nxt = '0;
                        off_nxt      = (align_offset == 4'd9) ? 4'd0 : align_offset + 4'd1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (!dec_de_p0) begin
                    loss_cnt_nxt = '0;
                end else if (loss_cnt == LOSS_LAST) begin
                    state_nxt    = SEARCH;
                    realign_nxt  = 1'b1;
                    loss_cnt_nxt = '0;
                    tok_cnt_nxt  = '0;
                    wait_cnt_nxt = '0;
                end else begin
                    loss_cnt_nxt = loss_cnt + 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_comb begin
        locked = (state == LOCKED);
    end

    // ---- stage p1: gated, registered decoder outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            vd <= 8'h00;
            cd <= 2'b00;
            de <= 1'b0;
        end else if (locked) begin
            vd <= dec_vd_p0;
            cd <= dec_cd_p0;
            de <= dec_de_p0;
        end else begin
            vd <= 8'h00;
            cd <= 2'b00;
            de <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tmds_channel_receiver.sv
// Directed bench for tmds_channel_receiver: a reference TMDS encoder feeds a
// bit-delayable serial stream; decoded outputs are checked with assertions.
module tb_tmds_channel_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] din = 10'd0;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       de;
    logic       locked;
    logic [3:0] align_offset;
    logic       realign;

    int errors = 0;
    int checks = 0;
    int disp = 0;
    bit sq[$];

    logic       pend = 1'b0;
    logic [10:0] p_exp = '0;
    string      p_tag = "";

    tmds_channel_receiver #(
        .LOCK_TOKENS (8),
        .SEARCH_WORDS(2048),
        .LOSS_WORDS  (4096)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .vd          (vd),
        .cd          (cd),
        .de          (de),
        .locked      (locked),
        .align_offset(align_offset),
        .realign     (realign)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] tok(input logic [1:0] c);
        disp = 0;
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Reference DVI 1.0 TMDS data encoder with running disparity in disp
    function automatic logic [9:0] enc_data(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] e;
        int n1, n1q, n0q;
        n1 = $countones(d);
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (disp == 0 || n1q == n0q) begin
            e = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            disp = qm[8] ? disp + n1q - n0q : disp + n0q - n1q;
        end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
            e = {1'b1, qm[8], ~qm[7:0]};
            disp = disp + 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            e = {1'b0, qm[8], qm[7:0]};
            disp = disp - 2 * int'(!qm[8]) + n1q - n0q;
        end
        return e;
    endfunction

    task automatic restart_stream(input int delay_bits);
        sq.delete();
        for (int i = 0; i < delay_bits; i++) sq.push_back(1'b0);
    endtask

    // Serialise w LSB-first, then present the next 10 bits of the wire to din
    task automatic put(input logic [9:0] w);
        logic [9:0] o;
        for (int i = 0; i < 10; i++) sq.push_back(w[i]);
        for (int i = 0; i < 10; i++) o[i] = sq.pop_front();
        din = o;
        @(posedge clk);
        #1;
    endtask

    // Output seen after a put belongs to the word put one call earlier
    task automatic put_exp(input logic [9:0] w, input logic e_de, input logic [7:0] e_vd,
                           input logic [1:0] e_cd, input string tag);
        put(w);
        if (pend) chk(p_tag, {21'd0, de, vd, cd}, {21'd0, p_exp});
        pend  = 1'b1;
        p_exp = {e_de, e_vd, e_cd};
        p_tag = tag;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        din   = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int lock_seen;
        int n;

        // Test 1: aligned stream, lock and first data latency
        do_reset();
        restart_stream(0);
        chk("rst_locked", locked, 0);
        chk("rst_de", de, 0);
        chk("rst_vd", vd, 0);
        chk("rst_cd", cd, 0);
        chk("rst_off", align_offset, 0);
        chk("rst_realign", realign, 0);
        repeat (8) put(tok(2'b00));
        chk("t1_prelock", locked, 0);
        put(tok(2'b00));
        chk("t1_lock", locked, 1);
        chk("t1_off", align_offset, 0);
        repeat (191) put(tok(2'b00));
        put(enc_data(8'h41));
        chk("t1_lat1_de", de, 0);
        put(enc_data(8'h41));
        chk("t1_lat2_de", de, 1);
        chk("t1_lat2_vd", vd, 8'h41);

        // Test 6: every byte at negative, zero and positive disparity, all codes
        pend = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 256; v++) begin
                disp = (k == 0) ? -2 : ((k == 1) ? 0 : 2);
                put_exp(enc_data(8'(v)), 1'b1, 8'(v), 2'b00, $sformatf("t6_vd_%0d_d%0d", v, k));
            end
        end
        for (int c = 0; c < 4; c++) begin
            put_exp(tok(2'(c)), 1'b0, 8'h00, 2'(c), $sformatf("t6_cd_%0d", c));
        end
        put_exp(tok(2'b00), 1'b0, 8'h00, 2'b00, "t6_flush");

        // Test 3: token runs one short of lock
        do_reset();
        restart_stream(0);
        disp = 0;
        lock_seen = 0;
        for (int r = 0; r < 2500; r++) begin
            for (int t = 0; t < 7; t++) begin
                put(tok(2'b00));
                lock_seen |= int'(locked);
            end
            put(enc_data(8'h41));
            lock_seen |= int'(locked);
        end
        chk("t3_nolock", lock_seen, 0);

        // Test 2: stream delayed by 3 bits, offset search
        do_reset();
        restart_stream(3);
        repeat (1000) put(tok(2'b00));
        chk("t2_off0", align_offset, 0);
        chk("t2_unlocked", locked, 0);
        repeat (2000) put(tok(2'b00));
        chk("t2_off1", align_offset, 1);
        repeat (2000) put(tok(2'b00));
        chk("t2_off2", align_offset, 2);
        n = 0;
        while (!locked && n < 3000) begin
            put(tok(2'b00));
            n++;
        end
        chk("t2_lock", locked, 1);
        chk("t2_off3", align_offset, 3);
        put(enc_data(8'h41));
        chk("t2_lat1_de", de, 0);
        put(enc_data(8'h41));
        chk("t2_lat2_de", de, 1);
        chk("t2_lat2_vd", vd, 8'h41);

        // Test 4: loss of lock after 4096 data-only words, then relock
        repeat (4) put(tok(2'b00));
        repeat (4096) put(enc_data(8'h41));
        chk("t4_still_locked", locked, 1);
        chk("t4_no_realign", realign, 0);
        put(tok(2'b00));
        chk("t4_realign", realign, 1);
        chk("t4_unlocked", locked, 0);
        put(tok(2'b00));
        chk("t4_realign_pulse", realign, 0);
        repeat (6) put(tok(2'b00));
        chk("t4_prelock", locked, 0);
        put(tok(2'b00));
        chk("t4_relock", locked, 1);
        chk("t4_off3", align_offset, 3);

        // Test 5: reset mid-line while locked
        repeat (3) put(enc_data(8'h41));
        chk("t5_de_before", de, 1);
        reset = 1'b1;
        put(enc_data(8'h41));
        reset = 1'b0;
        chk("t5_locked", locked, 0);
        chk("t5_de", de, 0);
        chk("t5_vd", vd, 0);
        chk("t5_off", align_offset, 0);
        chk("t5_realign", realign, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
